// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides on the sampling-clock domain.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_recv_if.sv
// One-entry receive handshake: the receiver presents rx_byte/rx_valid, the consumer answers with rx_ack.
interface uart_recv_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_valid;
    logic                 rx_ack;

    modport master (output rx_byte, output rx_valid, input rx_ack);
    modport slave  (input rx_byte, input rx_valid, output rx_ack);
endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser; RST_VAL lets a serial line read idle while in reset.
module uart_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_recv.sv
// 16x-oversampling 8N1 UART receiver with a one-entry output register, CTS flow control and error flags.
// Optional even-parity checking is built when UART_RECV_PARITY_EN is defined.
module uart_recv
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic        uart_sampling_clk,
    input  logic        rst_n,
    input  logic        USB_RX,
    output logic        USB_CTS,
    output logic        framing_err,
    output logic        overrun,
`ifdef UART_RECV_PARITY_EN
    output logic        parity_err,
`endif
    uart_recv_if.master rx
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;
`ifdef UART_RECV_PARITY_EN
    logic                 parity_bad;
`endif

    uart_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk   (uart_sampling_clk),
        .rst_n (rst_n),
        .d     (USB_RX),
        .q     (rx_s)
    );

    assign USB_CTS = rx.rx_valid;

    always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx.rx_byte  <= '0;
            rx.rx_valid <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            parity_bad  <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            parity_err  <= 1'b0;
`endif
            // Ack first; a good stop sample below may reload on the same edge.
            if (rx.rx_ack && rx.rx_valid) begin
                rx.rx_valid <= 1'b0;
                overrun     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_END) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RECV_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RECV_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_END) begin
                        cnt        <= '0;
                        parity_bad <= rx_s ^ (^shift);
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_END) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            framing_err <= 1'b1;
                            state       <= BREAK;
                        end else begin
                            state <= IDLE;
`ifdef UART_RECV_PARITY_EN
                            if (parity_bad) begin
                                parity_err <= 1'b1;
                            end else
`endif
                            if (rx.rx_valid && !rx.rx_ack) begin
                                overrun <= 1'b1;
                            end else begin
                                rx.rx_byte  <= shift;
                                rx.rx_valid <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // A held-low line reports once, then waits for idle.
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_recv.sv
// Directed self-checking bench for uart_recv: latency, glitch rejection, framing, overrun, same-edge ack, reset abort.
module tb_uart_recv;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic USB_RX;
    logic USB_CTS;
    logic framing_err;
    logic overrun;
`ifdef UART_RECV_PARITY_EN
    logic parity_err;
`endif

    uart_recv_if #(.DATA_BITS(8)) rx_if ();

    uart_recv dut (
        .uart_sampling_clk (clk),
        .rst_n             (rst_n),
        .USB_RX            (USB_RX),
        .USB_CTS           (USB_CTS),
        .framing_err       (framing_err),
        .overrun           (overrun),
`ifdef UART_RECV_PARITY_EN
        .parity_err        (parity_err),
`endif
        .rx                (rx_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int vld_cnt  = 0;
    int pe_cnt   = 0;

    always @(negedge clk) begin
        if (framing_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (rx_if.rx_valid === 1'b1) vld_cnt++;
`ifdef UART_RECV_PARITY_EN
        if (parity_err === 1'b1) pe_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives up to nbits bits of a frame, OS clocks each: start, data LSB first, [parity], stop.
    task automatic send(input logic [7:0] d, input logic stop_bit, input logic par_flip, input int nbits);
        logic [11:0] f;
        int len;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        len = 9;
`ifdef UART_RECV_PARITY_EN
        f[len] = (^d) ^ par_flip;
        len++;
`endif
        f[len] = stop_bit;
        len++;
        for (int i = 0; i < len && i < nbits; i++) begin
            USB_RX = f[i];
            wait_clk(OS);
        end
    endtask

    task automatic ack();
        rx_if.rx_ack = 1'b1;
        wait_clk(1);
        rx_if.rx_ack = 1'b0;
    endtask

    int fe0, ov0, vld0, pe0;

    initial begin
        USB_RX       = 1'b1;
        rx_if.rx_ack = 1'b0;
        rst_n        = 1'b0;
        wait_clk(3);
        chk("reset_byte", rx_if.rx_byte, 8'h00);
        chk("reset_valid", rx_if.rx_valid, 1'b0);
        chk("reset_cts", USB_CTS, 1'b0);
        chk("reset_fe", framing_err, 1'b0);
        chk("reset_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        wait_clk(10);

        // Latency of 0xA5 from the falling start edge.
        fork
            send(8'hA5, 1'b1, 1'b0, 99);
            begin
`ifdef UART_RECV_PARITY_EN
                wait_clk(154 + OS);
`else
                wait_clk(154);
`endif
                chk("a5_valid_early", rx_if.rx_valid, 1'b0);
                wait_clk(1);
                chk("a5_valid_on_time", rx_if.rx_valid, 1'b1);
                chk("a5_byte", rx_if.rx_byte, 8'hA5);
                chk("a5_cts", USB_CTS, 1'b1);
            end
        join
        ack();
        chk("a5_ack_valid", rx_if.rx_valid, 1'b0);
        chk("a5_ack_cts", USB_CTS, 1'b0);
        wait_clk(5);

        // Short low glitch must be rejected silently.
        fe0 = fe_cnt; ov0 = ov_cnt; vld0 = vld_cnt;
        USB_RX = 1'b0;
        wait_clk(4);
        USB_RX = 1'b1;
        wait_clk(40);
        chk("glitch_valid", vld_cnt - vld0, 0);
        chk("glitch_fe", fe_cnt - fe0, 0);
        chk("glitch_ovr", ov_cnt - ov0, 0);

        // Framing error, held-low break, then recovery.
        fe0 = fe_cnt;
        send(8'h3C, 1'b0, 1'b0, 99);
        chk("fe_one_pulse", fe_cnt - fe0, 1);
        chk("fe_valid", rx_if.rx_valid, 1'b0);
        wait_clk(100);
        chk("fe_break_no_more", fe_cnt - fe0, 1);
        USB_RX = 1'b1;
        wait_clk(20);
        send(8'h81, 1'b1, 1'b0, 99);
        chk("after_break_valid", rx_if.rx_valid, 1'b1);
        chk("after_break_byte", rx_if.rx_byte, 8'h81);
        ack();
        wait_clk(5);

        // Overrun: second byte dropped while the first is unconsumed.
        send(8'h11, 1'b1, 1'b0, 99);
        send(8'h22, 1'b1, 1'b0, 99);
        chk("ovr_byte", rx_if.rx_byte, 8'h11);
        chk("ovr_flag", overrun, 1'b1);
        ack();
        chk("ovr_ack_flag", overrun, 1'b0);
        chk("ovr_ack_valid", rx_if.rx_valid, 1'b0);
        wait_clk(5);

        // Ack on the same edge as the second stop sample.
        fork
            begin
                send(8'h11, 1'b1, 1'b0, 99);
                send(8'h22, 1'b1, 1'b0, 99);
            end
            begin
`ifdef UART_RECV_PARITY_EN
                wait_clk(10 * OS + 154 + 2 * OS);
`else
                wait_clk(10 * OS + 154);
`endif
                rx_if.rx_ack = 1'b1;
                wait_clk(1);
                rx_if.rx_ack = 1'b0;
            end
        join
        chk("same_edge_byte", rx_if.rx_byte, 8'h22);
        chk("same_edge_valid", rx_if.rx_valid, 1'b1);
        chk("same_edge_ovr", overrun, 1'b0);
        ack();
        wait_clk(5);

        // Reset in the middle of a frame while a byte and overrun are pending.
        send(8'h5A, 1'b1, 1'b0, 99);
        send(8'h5B, 1'b1, 1'b0, 99);
        chk("pre_rst_ovr", overrun, 1'b1);
        send(8'h96, 1'b1, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        chk("rst_byte", rx_if.rx_byte, 8'h00);
        chk("rst_valid", rx_if.rx_valid, 1'b0);
        chk("rst_cts", USB_CTS, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_fe", framing_err, 1'b0);
        USB_RX = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(20);
        send(8'hFF, 1'b1, 1'b0, 99);
        chk("post_rst_valid", rx_if.rx_valid, 1'b1);
        chk("post_rst_byte", rx_if.rx_byte, 8'hFF);
        ack();
        wait_clk(5);

`ifdef UART_RECV_PARITY_EN
        // Bad even parity: byte discarded with a single pulse.
        pe0 = pe_cnt;
        send(8'h07, 1'b1, 1'b1, 99);
        chk("par_pulse", pe_cnt - pe0, 1);
        chk("par_valid", rx_if.rx_valid, 1'b0);
`else
        pe0 = pe_cnt;
        chk("no_par_pulse", pe_cnt - pe0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- 16x-oversampling UART receiver. Receive-side counterpart of uart_trans; runs on the same uart_sampling_clk domain.
- Deserialises 8N1 frames from the USB bridge RX pin into bytes.
- Holds each byte in a one-entry output register until the consumer acks it.
- Drives USB_CTS flow control and flags framing and overrun errors.

Parameters:
- OVERSAMPLE, 16, sampling clocks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- uart_sampling_clk  input  1  sampling clock, OVERSAMPLE x baud.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- USB_RX  input  1  serial line from the USB bridge; idle high; asynchronous to the clock.
- rx_ack  input  1  consumer has taken rx_byte; only meaningful while rx_valid = 1.
- rx_byte  output  DATA_BITS  received byte; stable while rx_valid = 1.
- rx_valid  output  1  rx_byte holds an unconsumed byte.
- USB_CTS  output  1  active-low clear-to-send; 0 when rx_valid = 0, 1 when rx_valid = 1.
- framing_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; set when a good frame completes while rx_valid = 1; cleared by rx_ack.

Behaviour:
- Reset values: rx_byte = 0, rx_valid = 0, USB_CTS = 0, framing_err = 0, overrun = 0. FSM goes to IDLE, counters to 0.
- USB_RX passes through a 2-flop synchroniser; rx_s is the synchroniser output. All decisions use rx_s.
- IDLE:
  - rx_s = 0 -> START, cnt = 0.
- START:
  - cnt increments every clock.
  - At cnt = OVERSAMPLE/2-1 (mid start bit): rx_s = 1 -> IDLE (glitch, nothing reported); rx_s = 0 -> DATA, cnt = 0, bit_idx = 0.
- DATA:
  - At cnt = OVERSAMPLE-1: shift rx_s into the MSB of the shift register (LSB-first framing), bit_idx++, cnt = 0.
  - After DATA_BITS samples -> STOP.
- STOP:
  - At cnt = OVERSAMPLE-1, sample rx_s.
  - rx_s = 1 and rx_valid = 0: next cycle rx_byte = shift register, rx_valid = 1. Go to IDLE.
  - rx_s = 1 and rx_valid = 1: byte dropped, rx_byte unchanged, overrun set. Go to IDLE.
  - rx_s = 0: framing_err pulses one cycle, byte discarded. Go to BREAK.
- BREAK:
  - Wait for rx_s = 1, then -> IDLE. A held-low line produces exactly one framing_err.
- Handshake:
  - rx_ack with rx_valid = 1 clears rx_valid and overrun on the next edge.
  - rx_ack with rx_valid = 0 is ignored.
- Same-edge load and ack: if rx_ack and a good stop sample occur on the same edge, the ack consumes the old byte and the new byte loads (rx_valid stays 1, no overrun).
- Latency: falling pin edge to rx_valid rising is 2 + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE + 1 clocks. With default parameters this is 155 clocks.
- rst_n asserted mid-frame: everything aborts immediately; there is no partial output. After release the FSM waits in IDLE for the next low.

Optional Feature:
- UART_RECV_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP that samples an even-parity bit.
  - Adds output parity_err (1 bit): one-cycle pulse, aligned with the cycle in which rx_valid would load; the byte is discarded.
  - Frame length becomes DATA_BITS+3 bits; latency grows by OVERSAMPLE.
- Undefined: no parity state and no parity_err port; pure 8N1.

Decomposition:
- uart_pkg: rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK); localparams UART_OVERSAMPLE = 16 and UART_DATA_BITS = 8. Shared with uart_trans.
- Sub-module uart_sync2: generic 2-flop synchroniser with reset value 1, so the line reads idle during reset.

Test Plan:
- Byte 0xA5 sent at 16 clocks per bit, no ack -> rx_byte = 0xA5, rx_valid = 1 exactly 155 clocks after the start edge. USB_CTS = 1. Pulse rx_ack -> rx_valid = 0, USB_CTS = 0.
- Low glitch of 4 clocks on an idle line -> FSM returns to IDLE. rx_valid, framing_err and overrun stay 0.
- Frame 0x3C with stop bit driven 0 -> one framing_err pulse, rx_valid = 0. Line held low 100 more clocks -> no further pulse. Then send 0x81 -> received correctly.
- Send 0x11 then 0x22 with no ack -> rx_byte = 0x11, overrun = 1. rx_ack -> overrun = 0, rx_valid = 0.
- Send 0x11 and 0x22 back-to-back, with rx_ack on the same edge as the 0x22 stop sample -> rx_byte = 0x22, rx_valid = 1, overrun = 0.
- rst_n pulsed low at bit 4 of a frame -> all outputs at reset values. The next full frame 0xFF is received correctly.
- With UART_RECV_PARITY_EN: 0x07 sent with parity bit 0 (odd count of ones) -> parity_err pulses, rx_valid stays 0.
